// File: rtl/hc_pkg.sv
// Shared types and constants for the HC-SR04 ranging path.
package hc_pkg;

   localparam int          MM_W    = 14;
   localparam logic [15:0] BCD_ERR = 16'h9999;

   localparam int DEF_TRIG_CYCLES     = 500;
   localparam int DEF_PERIOD_CYCLES   = 3_000_000;
   localparam int DEF_CYC_PER_MM      = 294;
   localparam int DEF_ECHO_MAX_CYCLES = 1_500_000;
   localparam int DEF_MM_MAX          = 9999;

   // AVG is only entered when the averaging build is selected
   typedef enum logic [2:0] {
      IDLE, TRIG, WAIT_RISE, MEASURE, CONVERT, DONE, TIMEOUT, AVG
   } hc_state_t;

   // Double-dabble correction: any digit >= 5 gets +3 before the shift.
   function automatic logic [15:0] bcd_add3(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      for (int i = 0; i < 4; i++)
         if (v[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative 14-bit binary to 4-digit packed BCD, one bit per cycle, 14 cycles start to done.
module bin2bcd_seq
   import hc_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [MM_W-1:0] bin,
   output logic            done,
   output logic [15:0]     bcd
);

   logic [MM_W-1:0] sr;
   logic [3:0]      cnt;
   logic            busy;
   logic [15:0]     adj;

   assign adj = bcd_add3(bcd);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr   <= '0;
         bcd  <= '0;
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            // first shift folded into the load: a zero accumulator never needs +3
            sr   <= bin << 1;
            bcd  <= {15'd0, bin[MM_W-1]};
            cnt  <= 4'(MM_W - 1);
            busy <= 1'b1;
         end else if (busy) begin
            sr  <= sr << 1;
            bcd <= {adj[14:0], sr[MM_W-1]};
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/hc_sr04_ranger.sv
// HC-SR04 trigger/echo timer producing packed-BCD millimetres with a one-cycle valid strobe.
// Define HC_AVG4_EN to convert the running mean of the last four good readings.
module hc_sr04_ranger
   import hc_pkg::*;
#(
   parameter int TRIG_CYCLES     = DEF_TRIG_CYCLES,
   parameter int PERIOD_CYCLES   = DEF_PERIOD_CYCLES,
   parameter int CYC_PER_MM      = DEF_CYC_PER_MM,
   parameter int ECHO_MAX_CYCLES = DEF_ECHO_MAX_CYCLES,
   parameter int MM_MAX          = DEF_MM_MAX
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        echo,
   output logic        trig,
   output logic [15:0] hc_data,
   output logic        data_valid,
   output logic        range_err
);

   localparam int PER_W   = $clog2(PERIOD_CYCLES);
   localparam int TMR_MAX = (TRIG_CYCLES > ECHO_MAX_CYCLES) ? TRIG_CYCLES : ECHO_MAX_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int PRE_W   = (CYC_PER_MM > 1) ? $clog2(CYC_PER_MM) : 1;

   localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
   localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_CYCLES - 1);
   localparam logic [TMR_W-1:0] ECHO_LAST = TMR_W'(ECHO_MAX_CYCLES - 1);
   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CYC_PER_MM - 1);
   localparam logic [MM_W-1:0]  MM_SAT    = MM_W'(MM_MAX);

   hc_state_t        state, next_state;
   logic             echo_s1, echo_s;
   logic [PER_W-1:0] per_cnt;
   logic             per_wrap;
   logic [TMR_W-1:0] tmr;
   logic [PRE_W-1:0] pre;
   logic [MM_W-1:0]  mm_cnt;
   logic             cnt_en;
   logic             conv_start, conv_done;
   logic [MM_W-1:0]  conv_in;
   logic [15:0]      conv_bcd;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         echo_s1 <= 1'b0;
         echo_s  <= 1'b0;
      end else begin
         echo_s1 <= echo;
         echo_s  <= echo_s1;
      end
   end

   assign per_wrap = (per_cnt == PER_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        per_cnt <= '0;
      else if (per_wrap) per_cnt <= '0;
      else               per_cnt <= per_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      conv_start = 1'b0;
      case (state)
         IDLE:      if (per_wrap) next_state = TRIG;
         TRIG:      if (tmr == TRIG_LAST) next_state = WAIT_RISE;
         WAIT_RISE: begin
            if (echo_s)                 next_state = MEASURE;
            else if (tmr == ECHO_LAST)  next_state = TIMEOUT;
         end
         MEASURE: begin
            if (!echo_s) begin
`ifdef HC_AVG4_EN
               next_state = AVG;
`else
               next_state = CONVERT;
               conv_start = 1'b1;
`endif
            end else if (tmr == ECHO_LAST) begin
               next_state = TIMEOUT;
            end
         end
`ifdef HC_AVG4_EN
         AVG: begin
            next_state = CONVERT;
            conv_start = 1'b1;
         end
`endif
         CONVERT:   if (conv_done) next_state = DONE;
         DONE:      next_state = IDLE;
         TIMEOUT:   next_state = IDLE;
         default:   next_state = IDLE;
      endcase
   end

   // On entering MEASURE the rise-detect cycle already counts as one high cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         tmr <= '0;
      else if (state != next_state)
         tmr <= (next_state == MEASURE) ? TMR_W'(1) : '0;
      else if (state == TRIG || state == WAIT_RISE || state == MEASURE)
         tmr <= tmr + 1'b1;
   end

   assign cnt_en = echo_s && (state == WAIT_RISE || state == MEASURE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre    <= '0;
         mm_cnt <= '0;
      end else if (state == TRIG) begin
         pre    <= '0;
         mm_cnt <= '0;
      end else if (cnt_en) begin
         if (pre == PRE_LAST) begin
            pre <= '0;
            if (mm_cnt != MM_SAT) mm_cnt <= mm_cnt + 1'b1;
         end else begin
            pre <= pre + 1'b1;
         end
      end
   end

`ifdef HC_AVG4_EN
   logic [3:0][MM_W-1:0] hist;
   logic                 hist_vld;
   logic [MM_W+1:0]      hist_sum;

   // first good reading fills every slot so the mean starts at that value
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist     <= '0;
         hist_vld <= 1'b0;
      end else if (state == MEASURE && !echo_s) begin
         hist     <= hist_vld ? {hist[2:0], mm_cnt} : {4{mm_cnt}};
         hist_vld <= 1'b1;
      end
   end

   assign hist_sum = (MM_W+2)'(hist[0]) + (MM_W+2)'(hist[1])
                   + (MM_W+2)'(hist[2]) + (MM_W+2)'(hist[3]);
   assign conv_in  = hist_sum[MM_W+1:2];
`else
   assign conv_in  = mm_cnt;
`endif

   bin2bcd_seq u_bcd (
      .clk   (clk),
      .reset (reset),
      .start (conv_start),
      .bin   (conv_in),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         trig       <= 1'b0;
         hc_data    <= '0;
         data_valid <= 1'b0;
         range_err  <= 1'b0;
      end else begin
         trig       <= (next_state == TRIG);
         data_valid <= 1'b0;
         if (state == DONE) begin
            hc_data    <= conv_bcd;
            range_err  <= 1'b0;
            data_valid <= 1'b1;
         end else if (state == TIMEOUT) begin
            hc_data    <= BCD_ERR;
            range_err  <= 1'b1;
            data_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hc_sr04_ranger.sv
// Directed bench for hc_sr04_ranger: a main instance plus a low-MM_MAX instance sharing echo.
module tb_hc_sr04_ranger;

   localparam int TRIG_C  = 5;
   localparam int CPM     = 4;
   localparam int EMAX    = 2000;
   localparam int PERIOD  = 4100;
`ifdef HC_AVG4_EN
   localparam int LAT     = 19;
`else
   localparam int LAT     = 18;
`endif

   logic        clk, reset, echo;
   logic        trig, data_valid, range_err;
   logic [15:0] hc_data;
   logic        trig_s, data_valid_s, range_err_s;
   logic [15:0] hc_data_s;

   int checks = 0;
   int fails  = 0;

   hc_sr04_ranger #(
      .TRIG_CYCLES(TRIG_C), .PERIOD_CYCLES(PERIOD), .CYC_PER_MM(CPM),
      .ECHO_MAX_CYCLES(EMAX), .MM_MAX(9999)
   ) dut (
      .clk(clk), .reset(reset), .echo(echo), .trig(trig),
      .hc_data(hc_data), .data_valid(data_valid), .range_err(range_err)
   );

   hc_sr04_ranger #(
      .TRIG_CYCLES(TRIG_C), .PERIOD_CYCLES(PERIOD), .CYC_PER_MM(CPM),
      .ECHO_MAX_CYCLES(EMAX), .MM_MAX(300)
   ) dut_sat (
      .clk(clk), .reset(reset), .echo(echo), .trig(trig_s),
      .hc_data(hc_data_s), .data_valid(data_valid_s), .range_err(range_err_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic wait_trig(input string tag);
      int n;
      n = 0;
      while (trig !== 1'b1 && n < PERIOD + 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " trig_seen"}, 32'(trig), 32'd1);
   endtask

   // One measurement cycle; n counts negedges from the one where trig is first seen low.
   task automatic meas(input string tag, input int high, input bit stuck,
                       input logic [15:0] exp_d, input logic exp_e, input int exp_n,
                       input logic [15:0] exp_sat);
      int n;
      logic [15:0] held;
      wait_trig(tag);
      chk({tag, " trig_sync"}, 32'(trig_s), 32'(trig));
      n = 0;
      while (trig === 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " trig_width"}, n, TRIG_C);
      n = 0;
      if (high != 0 || stuck) echo = 1'b1;
      while (data_valid !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
         if (n == high && !stuck) echo = 1'b0;
      end
      echo = 1'b0;
      chk({tag, " latency"}, n, exp_n);
      chk({tag, " hc_data"}, 32'(hc_data), 32'(exp_d));
      chk({tag, " range_err"}, 32'(range_err), 32'(exp_e));
      chk({tag, " sat_valid"}, 32'(data_valid_s), 32'd1);
      chk({tag, " sat_data"}, 32'(hc_data_s), 32'(exp_sat));
      held = hc_data;
      @(negedge clk);
      chk({tag, " valid_1cyc"}, 32'(data_valid), 32'd0);
      chk({tag, " held"}, 32'(hc_data), 32'(held));
   endtask

   initial begin
      reset = 1'b0;
      echo  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst trig", 32'(trig), 32'd0);
      chk("rst hc_data", 32'(hc_data), 32'd0);
      chk("rst valid", 32'(data_valid), 32'd0);
      chk("rst err", 32'(range_err), 32'd0);
      reset = 1'b1;

`ifdef HC_AVG4_EN
      meas("avg100", 400, 1'b0, 16'h0100, 1'b0, 400 + LAT, 16'h0100);
      meas("avg200", 800, 1'b0, 16'h0125, 1'b0, 800 + LAT, 16'h0125);
      meas("avg300", 1200, 1'b0, 16'h0175, 1'b0, 1200 + LAT, 16'h0175);
      meas("avg400", 1600, 1'b0, 16'h0250, 1'b0, 1600 + LAT, 16'h0225);
`else
      meas("mm123", 4*123, 1'b0, 16'h0123, 1'b0, 4*123 + LAT, 16'h0123);
      meas("mm400trunc", 4*400+3, 1'b0, 16'h0400, 1'b0, 4*400+3 + LAT, 16'h0300);
      meas("short", 2, 1'b0, 16'h0000, 1'b0, 2 + LAT, 16'h0000);
      meas("norise", 0, 1'b0, 16'h9999, 1'b1, EMAX + 1, 16'h9999);
      meas("mm57", 4*57, 1'b0, 16'h0057, 1'b0, 4*57 + LAT, 16'h0057);
      meas("stuck", 0, 1'b1, 16'h9999, 1'b1, EMAX + 3, 16'h9999);
      meas("justunder", EMAX - 1, 1'b0, 16'h0499, 1'b0, EMAX - 1 + LAT, 16'h0300);
`endif

      // reset in the middle of an echo: everything clears at once
      wait_trig("rstmeas");
      while (trig === 1'b1) @(negedge clk);
      echo = 1'b1;
      repeat (100) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rstmeas trig", 32'(trig), 32'd0);
      chk("rstmeas hc_data", 32'(hc_data), 32'd0);
      chk("rstmeas valid", 32'(data_valid), 32'd0);
      chk("rstmeas err", 32'(range_err), 32'd0);
      echo = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // reset while the trigger is high drops it asynchronously
      wait_trig("rsttrig");
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rsttrig trig", 32'(trig), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      meas("recover", 4*123, 1'b0, 16'h0123, 1'b0, 4*123 + LAT, 16'h0123);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
